// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing one register-file write port between sources A and B,
// plus a busy scoreboard for RAW stalls. Optional forwarding: define WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              hazard
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data
`endif
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;
  logic [NREGS-1:0]  r_busy;

  logic              w_b_prio;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_xfer;
  logic              w_real_write;
  logic [ADDR_W-1:0] w_grant_addr;
  logic [DATA_W-1:0] w_grant_data;
  logic [NREGS-1:0]  w_busy_next;
  logic              w_rs_busy;
  logic              w_rt_busy;

  // NOTE: every always_comb output gets a default on its first line so no path leaves it unassigned (no latch).
  always_comb begin
    w_b_prio     = b_valid && (r_starve_cnt >= LIMIT);
    w_a_ready    = !rst && a_valid && (!w_b_prio || !b_valid);
    w_b_ready    = !rst && b_valid && !w_a_ready;
    w_xfer       = w_a_ready || w_b_ready;
    w_grant_addr = w_a_ready ? a_addr : b_addr;
    w_grant_data = w_a_ready ? a_data : b_data;
    // Writes to r0 are accepted but never reach the register file.
    w_real_write = w_xfer && (w_grant_addr != '0);
  end

  // Clear for the retiring write first, then set for the new issue so set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_write_en) w_busy_next[r_write_addr] = 1'b0;
    if (issue_en && (issue_addr != '0)) w_busy_next[issue_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses <= only; the busy vector is plain flops, so it can and must be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_busy       <= '0;
    end else begin
      if (w_b_ready || !b_valid) begin
        r_starve_cnt <= '0;
      end else if (w_a_ready && (r_starve_cnt < LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      r_write_en <= w_real_write;
      if (w_real_write) begin
        r_write_addr <= w_grant_addr;
        r_write_data <= w_grant_data;
      end
      r_busy <= w_busy_next;
    end
  end

  assign a_ready      = w_a_ready;
  assign b_ready      = w_b_ready;
  assign reg_write_en = r_write_en;
  assign write_addr   = r_write_addr;
  assign write_data   = r_write_data;

  assign w_rs_busy = (rs_addr != '0) && r_busy[rs_addr];
  assign w_rt_busy = (rt_addr != '0) && r_busy[rt_addr];

`ifdef WB_BYPASS_EN
  logic w_rs_issue;
  logic w_rt_issue;

  assign fwd_rs_hit  = r_write_en && (r_write_addr == rs_addr) && (rs_addr != '0);
  assign fwd_rt_hit  = r_write_en && (r_write_addr == rt_addr) && (rt_addr != '0);
  assign fwd_rs_data = r_write_data;
  assign fwd_rt_data = r_write_data;
  // A same-cycle re-issue of the register keeps it busy despite the forward.
  assign w_rs_issue  = !rst && issue_en && (issue_addr == rs_addr);
  assign w_rt_issue  = !rst && issue_en && (issue_addr == rt_addr);
  assign hazard = (w_rs_busy && !(fwd_rs_hit && !w_rs_issue)) ||
                  (w_rt_busy && !(fwd_rt_hit && !w_rt_issue));
`else
  assign hazard = w_rs_busy || w_rt_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (defaults DATA_W=32, ADDR_W=5, STARVE_LIMIT=3);
// forwarding checks are compiled in when WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        reg_write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        issue_en;
  logic [4:0]  issue_addr, rs_addr, rt_addr;
  logic        hazard;
`ifdef WB_BYPASS_EN
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;
`endif

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .reg_write_en (reg_write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .issue_en     (issue_en),
    .issue_addr   (issue_addr),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .hazard       (hazard)
`ifdef WB_BYPASS_EN
    ,
    .fwd_rs_hit   (fwd_rs_hit),
    .fwd_rt_hit   (fwd_rt_hit),
    .fwd_rs_data  (fwd_rs_data),
    .fwd_rt_data  (fwd_rt_data)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 5'd1; a_data = 32'h1; b_addr = 5'd2; b_data = 32'h2;
    issue_en = 1'b1; issue_addr = 5'd8; rs_addr = 5'd8; rt_addr = 5'd0;
    tick();
    settle();
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%0b exp=0", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%0b exp=0", b_ready); end
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL rst_wen got=%0b exp=0", reg_write_en); end
    total++; if (write_addr !== 5'd0) begin bad++; $display("FAIL rst_waddr got=%0d exp=0", write_addr); end
    total++; if (write_data !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%0h exp=0", write_data); end
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%0b exp=0", hazard); end
    tick();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; issue_en = 1'b0; rs_addr = 5'd0;
    tick();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hDEADBEEF;
    settle();
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_a_ready got=%0b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    settle();
    total++; if (reg_write_en !== 1'b1) begin bad++; $display("FAIL single_wen got=%0b exp=1", reg_write_en); end
    total++; if (write_addr !== 5'd7) begin bad++; $display("FAIL single_waddr got=%0d exp=7", write_addr); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%0h exp=deadbeef", write_data); end
    tick();
    settle();
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL single_wen_after got=%0b exp=0", reg_write_en); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata_hold got=%0h exp=deadbeef", write_data); end
  endtask

  task automatic test_starvation();
    // Expected grant per cycle with both sources held valid: A A A B A.
    logic [4:0] grant_b;
    grant_b = 5'b01000;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0011;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h0000_0022;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++;
      if (a_ready !== !grant_b[i] || b_ready !== grant_b[i]) begin
        bad++;
        $display("FAIL starve_grant cycle=%0d got a=%0b b=%0b exp a=%0b b=%0b",
                 i + 1, a_ready, b_ready, !grant_b[i], grant_b[i]);
      end
      tick();
      total++;
      if (reg_write_en !== 1'b1 || write_addr !== (grant_b[i] ? 5'd2 : 5'd1)) begin
        bad++;
        $display("FAIL starve_write cycle=%0d got en=%0b addr=%0d exp en=1 addr=%0d",
                 i + 1, reg_write_en, write_addr, grant_b[i] ? 2 : 1);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_same_dest();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'hAAAA_0006;
    tick();
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 5'd6; b_data = 32'hBBBB_0006;
    settle();
    total++; if (write_data !== 32'hAAAA_0006) begin bad++; $display("FAIL same_dest_first got=%0h exp=aaaa0006", write_data); end
    tick();
    b_valid = 1'b0;
    settle();
    total++;
    if (reg_write_en !== 1'b1 || write_addr !== 5'd6 || write_data !== 32'hBBBB_0006) begin
      bad++;
      $display("FAIL same_dest_last got en=%0b addr=%0d data=%0h exp en=1 addr=6 data=bbbb0006",
               reg_write_en, write_addr, write_data);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_1234;
    settle();
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL zero_b_ready got=%0b exp=1", b_ready); end
    tick();
    b_valid = 1'b0;
    settle();
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL zero_wen got=%0b exp=0", reg_write_en); end
    tick();
  endtask

  task automatic test_scoreboard();
    logic exp_hz;
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    issue_en = 1'b0; rs_addr = 5'd9; rt_addr = 5'd0;
    settle();
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_rs_busy got=%0b exp=1", hazard); end
    rs_addr = 5'd0; rt_addr = 5'd9;
    settle();
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_rt_busy got=%0b exp=1", hazard); end
    rs_addr = 5'd9; rt_addr = 5'd0;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hCAFE_0009;
    settle();
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_b_ready got=%0b exp=1", b_ready); end
    tick();
    b_valid = 1'b0;
    settle();
`ifdef WB_BYPASS_EN
    exp_hz = 1'b0;
    total++; if (fwd_rs_hit !== 1'b1) begin bad++; $display("FAIL sb_fwd_hit got=%0b exp=1", fwd_rs_hit); end
    total++; if (fwd_rs_data !== 32'hCAFE_0009) begin bad++; $display("FAIL sb_fwd_data got=%0h exp=cafe0009", fwd_rs_data); end
`else
    exp_hz = 1'b1;
`endif
    total++; if (hazard !== exp_hz) begin bad++; $display("FAIL sb_hazard_wcycle got=%0b exp=%0b", hazard, exp_hz); end
    tick();
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL sb_hazard_cleared got=%0b exp=0", hazard); end
    rs_addr = 5'd0;
  endtask

  task automatic test_collision();
    issue_en = 1'b1; issue_addr = 5'd4;
    tick();
    issue_en = 1'b0; b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0000_0404;
    tick();
    b_valid = 1'b0; issue_en = 1'b1; issue_addr = 5'd4; rs_addr = 5'd4;
    settle();
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL coll_hazard_wcycle got=%0b exp=1", hazard); end
    tick();
    issue_en = 1'b0;
    settle();
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL coll_busy_kept got=%0b exp=1", hazard); end
    rs_addr = 5'd0;
  endtask

  task automatic test_mid_reset();
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    issue_addr = 5'd5;
    tick();
    issue_en = 1'b0; rs_addr = 5'd3; rt_addr = 5'd5;
    settle();
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL mid_hazard_before got=%0b exp=1", hazard); end
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h0000_000A;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h0000_000B;
    rst = 1'b1;
    settle();
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got a=%0b b=%0b exp a=0 b=0", a_ready, b_ready); end
    tick();
    rst = 1'b0;
    settle();
    total++; if (reg_write_en !== 1'b0) begin bad++; $display("FAIL mid_wen got=%0b exp=0", reg_write_en); end
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL mid_hazard_after got=%0b exp=0", hazard); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL mid_first_grant got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready); end
    rs_addr = 5'd4; rt_addr = 5'd0;
    settle();
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL mid_busy4_cleared got=%0b exp=0", hazard); end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    settle();
    total++; if (write_addr !== 5'd10) begin bad++; $display("FAIL mid_first_write got=%0d exp=10", write_addr); end
    tick();
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; issue_en = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    issue_addr = '0; rs_addr = '0; rt_addr = '0;
    test_reset();
    test_single_a();
    test_starvation();
    test_same_dest();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
